// File: rtl/rr_arbiter16_pkg.sv
// Shared constants, state encoding and the 16-to-4 one-hot encoder.
package rr_arbiter16_pkg;

  localparam int unsigned N            = 16;
  localparam int unsigned IDW          = 4;
  localparam int unsigned MAX_HOLD_DEF = 15;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Encode a one-hot (or zero) vector to its binary index; zero maps to 0.
  function automatic logic [IDW-1:0] enc16(input logic [N-1:0] onehot);
    logic [IDW-1:0] id;
    id = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) id = id | IDW'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/rr_arbiter16_pick.sv
// Round-robin selector: first set request at or after ptr, with wrap.
module rr_pick16
  import rr_arbiter16_pkg::*;
(
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   sel_onehot,
  output logic [IDW-1:0] sel_id,
  output logic           any
);

  logic [2*N-1:0] rot_r;
  logic [2*N-1:0] rot_l;
  logic [N-1:0]   rot;
  logic [N-1:0]   first;

  // Rotate so ptr sits at bit 0, isolate lowest set bit, rotate back, encode.
  always_comb begin
    rot_r      = {req, req} >> ptr;
    rot        = rot_r[N-1:0];
    first      = rot & (~rot + 16'd1);
    rot_l      = {first, first} << ptr;
    sel_onehot = rot_l[2*N-1:N];
    sel_id     = enc16(sel_onehot);
    any        = |req;
  end

endmodule

// File: rtl/rr_arbiter16.sv
// 16-requester round-robin arbiter with done/drop/hold-limit release.
module rr_arbiter16
  import rr_arbiter16_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_vld,
  output logic           timeout
);

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] cnt;
  logic [N-1:0]   pick_onehot;
  logic [IDW-1:0] pick_id;
  logic           pick_any;

  rr_pick16 u_pick (
    .req        (req),
    .ptr        (ptr),
    .sel_onehot (pick_onehot),
    .sel_id     (pick_id),
    .any        (pick_any)
  );

  // Arbitration FSM with registered grant outputs; done beats timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      gnt     <= '0;
      gnt_id  <= '0;
      gnt_vld <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (en && pick_any) begin
            state   <= GRANT;
            gnt     <= pick_onehot;
            gnt_id  <= pick_id;
            gnt_vld <= 1'b1;
            cnt     <= IDW'(1);
          end
        end
        GRANT: begin
          if (done || !req[gnt_id] ||
              (MAX_HOLD != 0 && cnt == IDW'(MAX_HOLD))) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            gnt_vld <= 1'b0;
            cnt     <= '0;
            ptr     <= gnt_id + 4'd1;
            timeout <= !done && req[gnt_id];
          end else if (cnt != 4'hF) begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rr_arbiter16.md
Name: rr_arbiter16

Overview:
- 16-requester round-robin arbiter that shares one downstream resource between 16 request lines.
- Emits both a one-hot grant and its 4-bit binary index; the index path is the 16-to-4 encode function already used in the datapath.
- Holds each grant until the owner signals done, drops its request, or exceeds a hold limit.
- Sits between the requesters and the shared unit, and sequences who drives that unit each transaction.

Parameters:
- N, 16, number of requesters (fixed at 16; the encode width depends on it)
- IDW, 4, index width, log2(N)
- MAX_HOLD, 15, maximum cycles a grant may be held before forced release; 0 disables the timeout

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  arbitration enable; gates only new grants
- req  input  16  request vector, bit i = requester i
- done  input  1  current owner finished; sampled only in GRANT
- gnt  output  16  one-hot grant, all-zero when idle
- gnt_id  output  4  binary index of granted requester, 0 when gnt_vld=0
- gnt_vld  output  1  a grant is active
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD

Behaviour:
- One clock domain.
- Reset is synchronous and active-high on rst; the clock is clk.
- Reset values:
  - gnt=0, gnt_id=0, gnt_vld=0, timeout=0.
  - Internal state: pointer ptr=0, hold counter cnt=0, state IDLE.
- rst asserted mid-grant clears everything at that edge; no timeout pulse is emitted.
- States: IDLE, GRANT.
- IDLE:
  - If en=1 and req!=0, select the first set bit searching ptr, ptr+1, ..., 15, 0, ..., ptr-1, with modulo-16 wrap.
  - At the next edge: state=GRANT, gnt=onehot(sel), gnt_id=sel, gnt_vld=1, cnt=1.
  - Latency is 1 cycle from sampled request to registered grant.
  - If en=0 or req=0, remain IDLE with outputs zero.
  - done is ignored in IDLE.
- GRANT: a release condition is evaluated every cycle. In priority order:
  - (a) done=1: normal release.
  - (b) req[gnt_id]=0: owner dropped, release.
  - (c) MAX_HOLD!=0 and cnt==MAX_HOLD: forced release, with timeout=1 for exactly the cycle following that edge.
  - Otherwise: cnt increments (saturating at 4'hF width; it never wraps), and gnt, gnt_id and gnt_vld are held stable.
- On release, at that edge:
  - gnt=0, gnt_vld=0, gnt_id=0.
  - ptr = gnt_id+1 mod 16 (15 wraps to 0).
  - state=IDLE.
- There is a mandatory one-cycle idle bubble between consecutive grants, even with requests pending.
- Simultaneous events:
  - done and the timeout condition in the same cycle: treated as a done release; no timeout pulse.
  - done and a request drop in the same cycle: a single normal release.
- en deasserted during GRANT does not abort the current grant. It only blocks the next selection.
- Requests on other lines during GRANT have no effect until IDLE.
- gnt is always one-hot or zero. gnt_id always equals the encode of gnt. gnt_vld equals |gnt.
- Fairness: a requester that holds req high continuously is granted within 16 grant cycles.

Decomposition:
- Shared package holds:
  - constants N=16, IDW=4;
  - state encoding IDLE=1'b0, GRANT=1'b1;
  - the MAX_HOLD default.
- One sub-module is natural: rr_pick16.
  - Purely combinational.
  - Inputs: req[15:0], ptr[3:0]. Outputs: sel_onehot[15:0], sel_id[3:0], any.
  - Implementation: rotate by ptr, fixed-priority first-set, rotate back, then 16-to-4 encode.
- The top level holds the FSM, ptr, cnt and the output registers.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=16'hFFFF, en=1 -> gnt=0, gnt_id=0, gnt_vld=0, timeout=0; the first grant after rst falls is to index 0.
- Single requester: req=16'h0001, done pulsed on the 3rd grant cycle -> gnt=16'h0001 and gnt_id=0 for 3 cycles, then one idle cycle, then gnt=16'h0001 again (ptr=1 wraps around the search to reach 0).
- Wrap-around: req=16'h8001 held, done asserted on each first grant cycle -> gnt_id sequence 0,15,0,15, with gnt_vld toggling 1,0,1,0 between grants.
- Full rotation: req=16'hFFFF, en=1, done pulsed each grant cycle -> gnt_id 0,1,2,...,15,0; each gnt is one-hot and matches gnt_id.
- Timeout: MAX_HOLD=15, req=16'h0004, done=0 -> gnt_id=2 for 15 cycles, a single-cycle timeout pulse, then release; with req=16'h000C the next grant is gnt_id=3.
- Drop, enable and reset mid-grant:
  - req[5] dropped on the 4th cycle of grant 5 -> release at the next edge, no timeout.
  - en=0 during a grant -> the grant continues, and no new grant follows while en=0.
  - rst pulsed mid-grant -> all outputs 0 at the next edge, and the next grant restarts the search from index 0.
